ula_multiciclo: RTL and testbench

//  Multi-cycle ULA (ALU) directly downstream of the ULA control decoder: consumes the
//  4-bit ula_select code plus two operands and produces a registered result and zero flag.

---
 rtl/ula_multiciclo.sv | 134 +++++++++++++
 tb/tb_ula_multiciclo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: arithmetic/logic ops finish in one cycle, shifts iterate one bit
// per cycle behind a start/busy/done handshake.
module ula_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         ula_select,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_SLL = 4'b0011,
                         OP_SLT = 4'b0100, OP_SLTU = 4'b0101, OP_SRL = 4'b0110,
                         OP_SRA = 4'b0111, OP_XOR = 4'b1000, OP_OR = 4'b1001,
                         OP_AND = 4'b1010, OP_LUI = 4'b1011, OP_AUIPC = 4'b1100;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   shreg, shreg_nx, result_nx, shifted;
  logic [3:0]         op, op_nx;
  logic [SHAMT_W-1:0] count, count_nx;
  logic               zero_nx, done_nx, is_shift;

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (sel)
      OP_ADD, OP_AUIPC: r = a + b;
      OP_SUB:           r = a - b;
      OP_SLT:           r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU:          r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:           r = a ^ b;
      OP_OR:            r = a | b;
      OP_AND:           r = a & b;
      OP_LUI:           r = b;
      default:          r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] sel,
                                                  input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign is_shift = (ula_select == OP_SLL) || (ula_select == OP_SRL) ||
                    (ula_select == OP_SRA);
  assign shifted  = shift_step(op, shreg);
  assign busy     = (state == SHIFT);

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    op_nx     = op;
    count_nx  = count;
    result_nx = result;
    zero_nx   = zero;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_shift) begin
            shreg_nx = op_a;
            op_nx    = ula_select;
            count_nx = op_b[SHAMT_W-1:0];
            if (op_b[SHAMT_W-1:0] == '0) begin
              result_nx = op_a;
              zero_nx   = (op_a == '0);
              done_nx   = 1'b1;
            end else begin
              state_nx = SHIFT;
            end
          end else begin
            result_nx = alu_op(ula_select, op_a, op_b);
            zero_nx   = (result_nx == '0);
            done_nx   = 1'b1;
          end
        end
      end
      SHIFT: begin
        shreg_nx = shifted;
        count_nx = count - 1'b1;
        // Last step: commit the shifted value directly rather than waiting a cycle.
        if (count == SHAMT_W'(1)) begin
          result_nx = shifted;
          zero_nx   = (shifted == '0);
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      op     <= '0;
      count  <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      op     <= op_nx;
      count  <= count_nx;
      result <= result_nx;
      zero   <= zero_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed-vector bench for ula_multiciclo: latency, busy length, results and flags.
module tb_ula_multiciclo;

  logic        clk, rst_n, start, zero, busy, done;
  logic [3:0]  ula_select;
  logic [31:0] op_a, op_b, result;
  int          total, bad, lat, bcnt;

  ula_multiciclo #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ula_select(ula_select),
    .op_a(op_a), .op_b(op_b), .result(result), .zero(zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at the next rising edge, then wait (bounded) for done.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ula_select = sel; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    start = 0; ula_select = 0; op_a = 0; op_b = 0;
    rst_n = 0;
    #12;
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_no_done", {31'b0, done}, 32'h0);
    end

    run_op(4'b0001, 32'hFFFF_FFFF, 32'h1);
    check("add_lat", lat, 1);
    check("add_res", result, 32'h0);
    check("add_zero", {31'b0, zero}, 32'h1);
    @(posedge clk); #1;
    check("done_pulse_width", {31'b0, done}, 32'h0);
    run_op(4'b0010, 32'd5, 32'd7);
    check("sub_res", result, 32'hFFFF_FFFE);
    check("sub_zero", {31'b0, zero}, 32'h0);
    run_op(4'b0100, 32'hFFFF_FFFF, 32'h1);
    check("slt_res", result, 32'h1);
    run_op(4'b0101, 32'hFFFF_FFFF, 32'h1);
    check("sltu_res", result, 32'h0);
    check("sltu_zero", {31'b0, zero}, 32'h1);
    run_op(4'b1000, 32'hF0F0_1234, 32'h0FF0_1200);
    check("xor_res", result, 32'hFF00_0034);
    run_op(4'b1001, 32'hA000_0001, 32'h0500_0010);
    check("or_res", result, 32'hA500_0011);
    run_op(4'b1010, 32'hFF00_FF00, 32'h0F0F_0F0F);
    check("and_res", result, 32'h0F00_0F00);
    run_op(4'b1100, 32'h0000_1000, 32'h0002_0000);
    check("auipc_res", result, 32'h0002_1000);

    run_op(4'b0111, 32'h8000_0000, 32'd4);
    check("sra_lat", lat, 5);
    check("sra_busy", bcnt, 4);
    check("sra_res", result, 32'hF800_0000);
    run_op(4'b0110, 32'h8000_0000, 32'd4);
    check("srl_res", result, 32'h0800_0000);
    run_op(4'b0011, 32'h1, 32'd31);
    check("sll_lat", lat, 32);
    check("sll_res", result, 32'h8000_0000);

    run_op(4'b0011, 32'hDEAD_BEEF, 32'h20);
    check("sh0_lat", lat, 1);
    check("sh0_busy", bcnt, 0);
    check("sh0_res", result, 32'hDEAD_BEEF);

    // Start pulsed with new operands while a shift is in flight.
    @(negedge clk);
    start = 1; ula_select = 4'b0110; op_a = 32'h0000_F000; op_b = 32'd8;
    @(posedge clk); #1;
    ula_select = 4'b0001; op_a = 32'h1234_5678; op_b = 32'h1;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 3) start = 0;
      @(posedge clk); #1;
      lat++;
    end
    start = 0;
    check("busy_ign_lat", lat, 9);
    check("busy_ign_res", result, 32'h0000_00F0);
    @(posedge clk); #1;
    check("busy_ign_no_redo", {31'b0, done}, 32'h0);

    // Back-to-back: issue the next op during the done cycle.
    run_op(4'b0001, 32'd3, 32'd4);
    check("b2b_first", result, 32'd7);
    start = 1; ula_select = 4'b0011; op_a = 32'h3; op_b = 32'd2;
    @(posedge clk); #1;
    start = 0;
    check("b2b_accepted_busy", {31'b0, busy}, 32'h1);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat", lat, 3);
    check("b2b_second", result, 32'hC);

    // Abort a 10-bit shift with reset.
    @(negedge clk);
    start = 1; ula_select = 4'b0011; op_a = 32'h5; op_b = 32'd10;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_zero", {31'b0, zero}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1;
      check("abort_no_done", {31'b0, done}, 32'h0);
    end
    run_op(4'b1011, 32'hFFFF_FFFF, 32'h1234_5000);
    check("lui_res", result, 32'h1234_5000);
    check("lui_zero", {31'b0, zero}, 32'h0);
    run_op(4'b1111, 32'h1, 32'h2);
    check("bad_sel_lat", lat, 1);
    check("bad_sel_res", result, 32'h0);
    check("bad_sel_zero", {31'b0, zero}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
